// File: rtl/diff_core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : diff_core_pkg
// Description : Shared types for the diff-activation column path: the output
//               handshake state encoding, the tagged-group record, and a lane
//               nonzero test that honours 4-bit mode.
// Revision    : 1.0 - initial release
// ============================================================================
package diff_core_pkg;

  // Activation lane width carried in the tagged-group record
  localparam int DC_ACT_W = 8;
  // Activations per diff group
  localparam int DC_LANES = 6;

  // Output handshake state, explicit 2-bit encoding
  typedef logic [1:0] out_state_t;
  localparam out_state_t O_EMPTY    = 2'd0;
  localparam out_state_t O_OFFER    = 2'd1;
  localparam out_state_t O_WAIT_FIN = 2'd2;

  // One buffered group with its tags; guard_map[5] belongs to lane 0
  typedef struct packed {
    logic [DC_LANES-1:0]          guard_map;
    logic                         is_odd_row;
    logic                         end_of_row;
    logic [DC_LANES*DC_ACT_W-1:0] act;
  } col_tag_t;

  // In 4-bit mode only the low nibble carries the value, so upper bits are ignored
  function automatic logic lane_nonzero(input logic [DC_ACT_W-1:0] lane,
                                        input logic              bit4_mode);
    logic nz;
    if (bit4_mode) nz = (lane[3:0] != 4'd0);
    else           nz = (lane != '0);
    return nz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/diff_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : diff_sync_fifo
// Description : Generic single-clock FIFO with occupancy count. The head entry
//               is presented combinationally on rd_data. DEPTH must be a
//               power of two so the pointers wrap without extra logic.
// Revision    : 1.0 - initial release
// ============================================================================
module diff_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify requests against occupancy and advance pointers/count
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/pe_col_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : pe_col_dispatch
// Description : Feeds one PE column controller. Builds the per-group nonzero
//               guard map, tags row parity / end-of-row, buffers tagged groups
//               and offers them with valid/ready, then holds the dispatched
//               group's activations until the controller pulses finish.
//               ACT_W must equal diff_core_pkg::DC_ACT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_col_dispatch
  import diff_core_pkg::*;
#(
  parameter int ACT_W       = 8,
  parameter int MAX_ROW_GRP = 64,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_bit_mode,
  input  logic                             cfg_kernal_mode,
  input  logic [$clog2(MAX_ROW_GRP+1)-1:0] cfg_row_grp,
  output logic                             cfg_err,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [6*ACT_W-1:0]               in_act,
  output logic                             valid,
  input  logic                             ready,
  input  logic                             finish,
  output logic                             bit_mode_o,
  output logic                             kernal_mode_o,
  output logic [5:0]                       guard_map_o,
  output logic                             is_odd_row_o,
  output logic                             end_of_row_o,
  output logic [6*ACT_W-1:0]               act_data_o,
  output logic                             busy,
  output logic [15:0]                      zero_grp_cnt
);

  localparam int RG_W  = $clog2(MAX_ROW_GRP+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  // Configuration and row tracking
  logic             cfg_loaded_q, cfg_loaded_d;
  logic             bit_mode_q, bit_mode_d;
  logic             kernal_mode_q, kernal_mode_d;
  logic [RG_W-1:0]  row_grp_q, row_grp_d;
  logic [RG_W-1:0]  col_cnt_q, col_cnt_d;
  logic             odd_q, odd_d;
  logic             cfg_err_q, cfg_err_d;

  // Output side
  out_state_t       state_q, state_d;
  logic [6*ACT_W-1:0] act_q, act_d;
  logic [5:0]       guard_q, guard_d;
  logic             odd_row_q, odd_row_d;
  logic             eor_q, eor_d;
  logic [15:0]      zero_cnt_q, zero_cnt_d;

  // FIFO interface
  col_tag_t         new_tag;
  col_tag_t         head_tag;
  logic [CNT_W-1:0] fifo_count;
  logic             push, pop;
  logic [RG_W-1:0]  last_col;

  // Input acceptance uses only the registered count, so a same-cycle pop never frees a slot
  always_comb begin
    busy     = (fifo_count != '0) || (state_q == O_WAIT_FIN);
    in_ready = cfg_loaded_q && (fifo_count < CNT_W'(FIFO_DEPTH));
    push     = in_valid && in_ready;
    last_col = (row_grp_q == '0) ? '0 : (row_grp_q - RG_W'(1));
  end

  // Tag the incoming group; lane 0 lands in the guard MSB so lanes are visited 0..5
  always_comb begin
    new_tag = '0;
    for (int i = 0; i < 6; i++) begin
      new_tag.guard_map[5-i] = lane_nonzero(in_act[i*ACT_W +: ACT_W], bit_mode_q);
    end
    new_tag.is_odd_row = odd_q;
    new_tag.end_of_row = (col_cnt_q == last_col);
    new_tag.act        = in_act;
  end

  // Config latch (only when idle) and per-row column/parity tracking
  always_comb begin
    cfg_loaded_d  = cfg_loaded_q;
    bit_mode_d    = bit_mode_q;
    kernal_mode_d = kernal_mode_q;
    row_grp_d     = row_grp_q;
    col_cnt_d     = col_cnt_q;
    odd_d         = odd_q;
    cfg_err_d     = cfg_start && busy;
    if (cfg_start && !busy) begin
      cfg_loaded_d  = 1'b1;
      bit_mode_d    = cfg_bit_mode;
      kernal_mode_d = cfg_kernal_mode;
      row_grp_d     = cfg_row_grp;
      col_cnt_d     = '0;
      odd_d         = 1'b1;
    end else if (push) begin
      if (col_cnt_q == last_col) begin
        col_cnt_d = '0;
        odd_d     = ~odd_q;
      end else begin
        col_cnt_d = col_cnt_q + RG_W'(1);
      end
    end
  end

  // Config and row-tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_loaded_q  <= 1'b0;
      bit_mode_q    <= 1'b0;
      kernal_mode_q <= 1'b0;
      row_grp_q     <= '0;
      col_cnt_q     <= '0;
      odd_q         <= 1'b1;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_loaded_q  <= cfg_loaded_d;
      bit_mode_q    <= bit_mode_d;
      kernal_mode_q <= kernal_mode_d;
      row_grp_q     <= row_grp_d;
      col_cnt_q     <= col_cnt_d;
      odd_q         <= odd_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  diff_sync_fifo #(
    .WIDTH ($bits(col_tag_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (new_tag),
    .pop     (pop),
    .rd_data (head_tag),
    .count   (fifo_count)
  );

  // Output handshake: offer head, capture it on accept, hold until finish
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    act_d      = act_q;
    guard_d    = guard_q;
    odd_row_d  = odd_row_q;
    eor_d      = eor_q;
    zero_cnt_d = zero_cnt_q;
    case (state_q)
      O_EMPTY: begin
        // A push this cycle lands in the FIFO at the edge, so offer right after
        if ((fifo_count != '0) || push) state_d = O_OFFER;
      end
      O_OFFER: begin
        if (ready) begin
          pop       = 1'b1;
          act_d     = head_tag.act;
          guard_d   = head_tag.guard_map;
          odd_row_d = head_tag.is_odd_row;
          eor_d     = head_tag.end_of_row;
          if ((head_tag.guard_map == 6'd0) && (zero_cnt_q != 16'hFFFF))
            zero_cnt_d = zero_cnt_q + 16'd1;
          state_d = O_WAIT_FIN;
        end
      end
      O_WAIT_FIN: begin
        if (finish) state_d = ((fifo_count != '0) || push) ? O_OFFER : O_EMPTY;
      end
      default: state_d = O_EMPTY;
    endcase
  end

  // Output-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= O_EMPTY;
      act_q      <= '0;
      guard_q    <= '0;
      odd_row_q  <= 1'b0;
      eor_q      <= 1'b0;
      zero_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      guard_q    <= guard_d;
      odd_row_q  <= odd_row_d;
      eor_q      <= eor_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  // Tag outputs follow the FIFO head while offering and the captured copy while in flight
  always_comb begin
    valid        = (state_q == O_OFFER);
    guard_map_o  = '0;
    is_odd_row_o = 1'b0;
    end_of_row_o = 1'b0;
    case (state_q)
      O_OFFER: begin
        guard_map_o  = head_tag.guard_map;
        is_odd_row_o = head_tag.is_odd_row;
        end_of_row_o = head_tag.end_of_row;
      end
      O_WAIT_FIN: begin
        guard_map_o  = guard_q;
        is_odd_row_o = odd_row_q;
        end_of_row_o = eor_q;
      end
      default: ;
    endcase
  end

  assign cfg_err       = cfg_err_q;
  assign bit_mode_o    = bit_mode_q;
  assign kernal_mode_o = kernal_mode_q;
  assign act_data_o    = act_q;
  assign zero_grp_cnt  = zero_cnt_q;

endmodule
`default_nettype wire
